multiplier_booth_r4: RTL

Parametrised sequential signed fixed-point multiplier for the ODE datapath. It uses radix-4 Booth recoding, so it retires two multiplier bits per cycle. Word width, fraction bits, rounding and saturation are configurable. It has valid/ready handshakes on both sides and a registered result that is held under backpressure. It replaces the fixed 16-bit radix-2 unit wherever the integrator stages need a multiply.

---
 rtl/fixed_point_pkg.sv | 57 +++++
 rtl/booth_r4_encoder.sv | 41 ++++
 rtl/multiplier_booth_r4.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fixed_point_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_point_pkg
//  Description : Shared types and helpers for the fixed-point multipliers:
//                FSM state encoding, radix-4 Booth select codes, the Booth
//                triplet decoder and the saturation-limit builder.
//  Revision    : 1.0 - initial release
// ============================================================================
package fixed_point_pkg;

    // Sequencer states of the iterative multiplier
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Partial-product selections produced by radix-4 Booth recoding
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        PA   = 3'd1,
        P2A  = 3'd2,
        NA   = 3'd3,
        N2A  = 3'd4
    } booth_sel_t;

    // Map the triplet {b[2i+1], b[2i], b[2i-1]} to its Booth digit
    function automatic booth_sel_t booth_decode(input logic [2:0] triplet);
        booth_sel_t sel;
        case (triplet)
            3'b001, 3'b010: sel = PA;
            3'b011:         sel = P2A;
            3'b100:         sel = N2A;
            3'b101, 3'b110: sel = NA;
            default:        sel = ZERO;
        endcase
        return sel;
    endfunction

    // Two's-complement limit for a given width: most positive when
    // negative=0, most negative when negative=1. Valid for width <= 64.
    function automatic logic [63:0] sat_limit(input int width, input logic negative);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width - 1) begin
                v[i] = ~negative;
            end else if (i == width - 1) begin
                v[i] = negative;
            end
        end
        return v;
    endfunction

endpackage : fixed_point_pkg
`default_nettype wire

// File: rtl/booth_r4_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : booth_r4_encoder
//  Description : Combinational radix-4 Booth partial-product generator.
//                Produces one of {0, +A, +2A, -A, -2A} as a signed
//                (WIDTH+2)-bit value; two guard bits let -2A of the most
//                negative A be represented exactly.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_r4_encoder
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic [2:0]       triplet,
    input  logic [WIDTH-1:0] multiplicand,
    output logic [WIDTH+1:0] partial
);

    logic [WIDTH+1:0] w_a_ext;
    logic [WIDTH+1:0] w_a2_ext;
    booth_sel_t       w_sel;

    assign w_a_ext  = {{2{multiplicand[WIDTH-1]}}, multiplicand};
    assign w_a2_ext = {w_a_ext[WIDTH:0], 1'b0};
    assign w_sel    = booth_decode(triplet);

    // Select the signed multiple of A requested by the Booth digit
    always_comb begin
        partial = '0;
        case (w_sel)
            PA:      partial = w_a_ext;
            P2A:     partial = w_a2_ext;
            NA:      partial = -w_a_ext;
            N2A:     partial = -w_a2_ext;
            default: partial = '0;
        endcase
    end

endmodule : booth_r4_encoder
`default_nettype wire

// File: rtl/multiplier_booth_r4.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_booth_r4
//  Description : Sequential signed fixed-point multiplier, radix-4 Booth,
//                two multiplier bits per cycle. Optional round-half-up and
//                saturation, valid/ready on both sides, result held until
//                the consumer takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiplier_booth_r4
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 7
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic             round_en,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow_flag
);

    localparam int               STEPS       = WIDTH / 2;
    localparam int               CNT_W       = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(STEPS - 1);
    localparam logic [WIDTH-1:0] C_SAT_MAX   = WIDTH'(sat_limit(WIDTH, 1'b0));
    localparam logic [WIDTH-1:0] C_SAT_MIN   = WIDTH'(sat_limit(WIDTH, 1'b1));
    // Width of the rounded product with the discarded fraction bits removed
    localparam int               HI_W        = 2 * WIDTH - FRAC;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [WIDTH+1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_round;
    logic             r_sat;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;
    logic             r_out_valid;

    logic [WIDTH+1:0] w_pp;
    logic [WIDTH+1:0] w_sum;
    logic             w_last_step;
    logic [HI_W-1:0]  w_r_hi;
    logic [WIDTH-FRAC:0] w_ovf_field;
    logic             w_ovf;
    logic [WIDTH-1:0] w_result;

    assign in_ready      = (r_state == IDLE);
    assign out_valid     = r_out_valid;
    assign result        = r_result;
    assign overflow_flag = r_ovf;

    assign w_last_step = (r_cnt == C_LAST_STEP);

    booth_r4_encoder #(
        .WIDTH (WIDTH)
    ) u_encoder (
        .triplet      ({r_q[1], r_q[0], r_qm1}),
        .multiplicand (r_a),
        .partial      (w_pp)
    );

    assign w_sum = r_acc + w_pp;

    // Rounding adds 2^(FRAC-1); below bit FRAC that only matters through the
    // carry it produces, which is exactly bit FRAC-1 of the raw product.
    assign w_r_hi = {r_acc[WIDTH-1:0], r_q[WIDTH-1:FRAC]}
                  + HI_W'(r_round & r_q[FRAC-1]);

    assign w_ovf_field = w_r_hi[HI_W-1:WIDTH-1];
    assign w_ovf       = !((&w_ovf_field) || (~|w_ovf_field));

    // Pick wrapped or clamped result for the FIN cycle
    always_comb begin
        w_result = w_r_hi[WIDTH-1:0];
        if (r_sat && w_ovf) begin
            w_result = w_r_hi[HI_W-1] ? C_SAT_MIN : C_SAT_MAX;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept, iterate, finish, wait for consumer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)    w_state_next = RUN;
            RUN:     if (w_last_step) w_state_next = FIN;
            FIN:                      w_state_next = DONE;
            DONE:    if (out_ready)   w_state_next = IDLE;
            default:                  w_state_next = IDLE;
        endcase
    end

    // Operand capture and Booth iteration over {acc, Q, q_-1}
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_round <= 1'b0;
            r_sat   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (in_valid) begin
                r_a     <= multiplicand;
                r_q     <= multiplier;
                r_qm1   <= 1'b0;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_round <= round_en;
                r_sat   <= sat_en;
            end
        end else if (r_state == RUN) begin
            r_acc <= {{2{w_sum[WIDTH+1]}}, w_sum[WIDTH+1:2]};
            r_q   <= {w_sum[1:0], r_q[WIDTH-1:2]};
            r_qm1 <= r_q[1];
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Output registers: loaded in FIN, held through DONE until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= (w_state_next == DONE);
            if (r_state == FIN) begin
                r_result <= w_result;
                r_ovf    <= w_ovf;
            end
        end
    end

endmodule : multiplier_booth_r4
`default_nettype wire
